// File: rtl/decoder_2to4_pkg.sv
// Shared constants and helpers for the registered 2-to-4 decoder.
// Optional per-lane event counters are enabled by defining DECODER_2TO4_CNT_EN.
package decoder_2to4_pkg;

  localparam int SEL_W = 2;
  localparam int OUT_W = 4;

  // Active-high one-hot image of a binary select.
  function automatic logic [OUT_W-1:0] onehot(input logic [SEL_W-1:0] sel);
    logic [OUT_W-1:0] vec;
    vec      = '0;
    vec[sel] = 1'b1;
    return vec;
  endfunction

  // Idle pattern of the strobe bus for a given output polarity.
  function automatic logic [OUT_W-1:0] idle_pattern(input logic active_low);
    return active_low ? {OUT_W{1'b1}} : {OUT_W{1'b0}};
  endfunction

endpackage

// File: rtl/decoder_2to4_sat_cnt.sv
// Saturating up-counter with synchronous active-low clear.
// Holds at all-ones instead of wrapping; only rst_n clears it.
module decoder_2to4_sat_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic         at_max;

  assign at_max = &cnt_q;

  // Next count: advance on inc unless already saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (inc && !at_max) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register; reset wins over any increment on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/decoder_2to4.sv
// Registered 2-to-4 one-hot decoder with enable.
// s/s_vld are registered one cycle after a/en; no combinational input-to-output path.
// OUT_ACTIVE_LOW=1 turns the bus into a one-cold strobe (reset/idle value 4'b1111).
// Defining DECODER_2TO4_CNT_EN adds four CNT_W-bit saturating per-lane event
// counters exposed on sel_cnt (lane i at bits [i*CNT_W +: CNT_W]).
module decoder_2to4
  import decoder_2to4_pkg::*;
#(
  parameter bit OUT_ACTIVE_LOW = 1'b0,
  parameter int CNT_W          = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [SEL_W-1:0]     a,
  input  logic                 en,
  output logic [OUT_W-1:0]     s,
  output logic                 s_vld
`ifdef DECODER_2TO4_CNT_EN
  ,
  output logic [OUT_W*CNT_W-1:0] sel_cnt
`endif
);

  localparam logic [OUT_W-1:0] IDLE_S = idle_pattern(OUT_ACTIVE_LOW);

  logic [OUT_W-1:0] dec_raw;
  logic [OUT_W-1:0] s_d;
  logic [OUT_W-1:0] s_q;
  logic             s_vld_d;
  logic             s_vld_q;

  assign dec_raw = onehot(a);

  // Next strobe value: decoded lane when enabled, idle pattern otherwise.
  always_comb begin
    s_d     = IDLE_S;
    s_vld_d = 1'b0;
    if (en) begin
      s_d     = dec_raw ^ IDLE_S;
      s_vld_d = 1'b1;
    end
  end

  // Output registers; synchronous reset forces the idle pattern on that edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_q     <= IDLE_S;
      s_vld_q <= 1'b0;
    end else begin
      s_q     <= s_d;
      s_vld_q <= s_vld_d;
    end
  end

  assign s     = s_q;
  assign s_vld = s_vld_q;

`ifdef DECODER_2TO4_CNT_EN
  // One saturating counter per lane, bumped whenever that lane is strobed.
  for (genvar i = 0; i < OUT_W; i++) begin : g_lane_cnt
    logic             lane_inc;
    logic [CNT_W-1:0] lane_cnt;

    assign lane_inc = en & dec_raw[i];

    decoder_2to4_sat_cnt #(
      .W (CNT_W)
    ) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (lane_inc),
      .cnt   (lane_cnt)
    );

    assign sel_cnt[i*CNT_W +: CNT_W] = lane_cnt;
  end
`else
  // CNT_W only sizes the optional counters; a non-positive width is left as an
  // empty marker block so the default build still elaborates the parameter.
  if (CNT_W < 1) begin : g_cnt_w_unused
  end
`endif

endmodule

// File: tb/tb_decoder_2to4.sv
module tb_decoder_2to4;
  localparam int CW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       en;
  logic [1:0] a;
  logic [3:0] s_hi, s_lo;
  logic       vld_hi, vld_lo;
`ifdef DECODER_2TO4_CNT_EN
  logic [4*CW-1:0] cnt_hi, cnt_lo;
`endif

  int total = 0;
  int bad   = 0;

  // Reference model state: value of s (active-high view), valid, lane counts.
  int m_s;
  int m_vld;
  int m_cnt [4];

  decoder_2to4 #(.OUT_ACTIVE_LOW(1'b0), .CNT_W(CW)) u_hi (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .en    (en),
    .s     (s_hi),
    .s_vld (vld_hi)
`ifdef DECODER_2TO4_CNT_EN
    ,
    .sel_cnt (cnt_hi)
`endif
  );

  decoder_2to4 #(.OUT_ACTIVE_LOW(1'b1), .CNT_W(CW)) u_lo (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .en    (en),
    .s     (s_lo),
    .s_vld (vld_lo)
`ifdef DECODER_2TO4_CNT_EN
    ,
    .sel_cnt (cnt_lo)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input bit r, input bit e, input int sel);
    if (!r) begin
      m_s = 0;
      m_vld = 0;
      foreach (m_cnt[i]) m_cnt[i] = 0;
    end else if (e) begin
      m_s = 2 ** sel;
      m_vld = 1;
      if (m_cnt[sel] < 2 ** CW - 1) m_cnt[sel] = m_cnt[sel] + 1;
    end else begin
      m_s = 0;
      m_vld = 0;
    end
  endtask

  task automatic step(input bit r, input bit e, input int sel);
    rst_n = r;
    en    = e;
    a     = 2'(sel);
    @(posedge clk);
    model_edge(r, e, sel);
    #1;
    check("s_hi", {28'b0, s_hi}, 32'(m_s));
    check("s_lo", {28'b0, s_lo}, 32'(15 - m_s));
    check("vld_hi", {31'b0, vld_hi}, 32'(m_vld));
    check("vld_lo", {31'b0, vld_lo}, 32'(m_vld));
`ifdef DECODER_2TO4_CNT_EN
    for (int i = 0; i < 4; i++) begin
      check($sformatf("cnt_hi[%0d]", i), 32'(cnt_hi[i*CW +: CW]), 32'(m_cnt[i]));
      check($sformatf("cnt_lo[%0d]", i), 32'(cnt_lo[i*CW +: CW]), 32'(m_cnt[i]));
    end
`endif
  endtask

  initial begin
    logic [3:0] sweep_exp [4];
    logic [1:0] cnt3_exp [5];
    sweep_exp[0] = 4'b0001; sweep_exp[1] = 4'b0010;
    sweep_exp[2] = 4'b0100; sweep_exp[3] = 4'b1000;
    cnt3_exp[0] = 2'd1; cnt3_exp[1] = 2'd2; cnt3_exp[2] = 2'd3;
    cnt3_exp[3] = 2'd3; cnt3_exp[4] = 2'd3;
    m_s = 0;
    m_vld = 0;
    foreach (m_cnt[i]) m_cnt[i] = 0;

    // Reset for two cycles
    step(0, 0, 0);
    step(0, 0, 0);
    check("rst_s_hi", {28'b0, s_hi}, 32'h0);
    check("rst_s_lo", {28'b0, s_lo}, 32'hF);
    check("rst_vld", {31'b0, vld_hi}, 32'h0);

    // Sweep with no bubbles
    for (int i = 0; i < 4; i++) begin
      step(1, 1, i);
      check($sformatf("sweep_s%0d", i), {28'b0, s_hi}, {28'b0, sweep_exp[i]});
      check($sformatf("sweep_vld%0d", i), {31'b0, vld_hi}, 32'h1);
    end

    // Disable
    step(1, 0, 3);
    check("dis_s", {28'b0, s_hi}, 32'h0);
    check("dis_vld", {31'b0, vld_hi}, 32'h0);

    // Reset mid-operation
    step(1, 1, 2);
    check("mid_pre", {28'b0, s_hi}, 32'h4);
    step(0, 1, 2);
    check("mid_rst", {28'b0, s_hi}, 32'h0);
    check("mid_rst_lo", {28'b0, s_lo}, 32'hF);
    step(1, 1, 2);
    check("mid_post", {28'b0, s_hi}, 32'h4);

    // Polarity
    step(1, 1, 1);
    check("pol_lo", {28'b0, s_lo}, 32'hD);
    check("pol_hi", {28'b0, s_hi}, 32'h2);

    // Counter saturation on lane 3
    step(0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      step(1, 1, 3);
`ifdef DECODER_2TO4_CNT_EN
      check($sformatf("cnt3_%0d", k), 32'(cnt_hi[3*CW +: CW]), 32'(cnt3_exp[k]));
      check($sformatf("cnt0_%0d", k), 32'(cnt_hi[0 +: CW]), 32'h0);
`else
      check($sformatf("hold3_%0d", k), {28'b0, s_hi}, 32'h8);
`endif
    end

    // Randomized traffic against the model
    for (int n = 0; n < 300; n++) begin
      step(($urandom_range(15) != 0), $urandom_range(1), $urandom_range(3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
